// File: rtl/counter_8bit_ctrl.sv
// Sequencer for an 8-bit loadable counter: preset, count N cycles, read back, compare.
// Define CTRL_ERRCNT_EN to build the saturating mismatch counter behind err_count.
module counter_8bit_ctrl #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] preset,
    input  logic [7:0] count_len,
    output logic       cnt_en,
    output logic       cnt_load,
    output logic [7:0] cnt_data_in,
    output logic       cnt_out_en,
    input  logic [7:0] cnt_data_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] result,
    output logic [7:0] err_count
);
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 2;

    typedef enum logic [2:0] {IDLE, LOAD, COUNT, READ, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] len_q, len_nxt;
    logic [DW-1:0] exp_q, exp_nxt;
    logic [DW-1:0] rem_q, rem_nxt;
    logic [RW-1:0] rd_q, rd_nxt;
    logic [DW-1:0] data_in_nxt, result_nxt;
    logic          pass_nxt;

    // State, sequencing counters and outputs; strobes are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            exp_q       <= '0;
            rem_q       <= '0;
            rd_q        <= '0;
            cnt_data_in <= '0;
            result      <= '0;
            pass        <= 1'b0;
            cnt_en      <= 1'b0;
            cnt_load    <= 1'b0;
            cnt_out_en  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            len_q       <= len_nxt;
            exp_q       <= exp_nxt;
            rem_q       <= rem_nxt;
            rd_q        <= rd_nxt;
            cnt_data_in <= data_in_nxt;
            result      <= result_nxt;
            pass        <= pass_nxt;
            cnt_en      <= (state_nxt == COUNT);
            cnt_load    <= (state_nxt == LOAD);
            cnt_out_en  <= (state_nxt == READ);
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == DONE);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        exp_nxt     = exp_q;
        rem_nxt     = rem_q;
        rd_nxt      = rd_q;
        data_in_nxt = cnt_data_in;
        result_nxt  = result;
        pass_nxt    = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt     = count_len;
                    exp_nxt     = DW'(preset + count_len);
                    data_in_nxt = preset;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                rem_nxt   = len_q;
                rd_nxt    = RW'(READ_LAT);
                state_nxt = (len_q != '0) ? COUNT : READ;
            end
            COUNT: begin
                rem_nxt = rem_q - DW'(1);
                if (rem_q == DW'(1)) state_nxt = READ;
            end
            READ: begin
                if (rd_q == '0) begin
                    result_nxt = cnt_data_out;
                    pass_nxt   = (cnt_data_out == exp_q);
                    state_nxt  = DONE;
                end else begin
                    rd_nxt = rd_q - RW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CTRL_ERRCNT_EN
    logic [DW-1:0] err_q;

    // Saturating count of failed checks, updated together with result/pass
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (state == READ && state_nxt == DONE && !pass_nxt && err_q != '1) begin
            err_q <= err_q + DW'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule
